// File: rtl/pipe_tx_skp_inserter.sv
// Per-lane PIPE TX stage: lane FIFO plus periodic SKP ordered-set insertion between packets.
// Optional SKP_INSERT_STATS_EN adds a wrapping 16-bit skp_count output.
module pipe_tx_skp_inserter #(
    parameter int unsigned SKP_INTERVAL = 295,
    parameter int unsigned CNT_W        = 12,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        skp_en,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] TxData,
    output logic [3:0]  TxDataK,
    output logic        TxDataValid,
    output logic        skp_sent,
    output logic        missed_skp
`ifdef SKP_INSERT_STATS_EN
    ,
    output logic [15:0] skp_count
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] SkpWord = 32'h1C1C1CBC;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [PtrW:0] FifoFullCount = (PtrW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  datak;
        logic        sop;
        logic        eop;
    } laneWordT;

    // StSkp marks the cycle a SKP word is on TxData.
    typedef enum logic [0:0] {
        StPass,
        StSkp
    } stateT;

    stateT stateQ, stateD;

    laneWordT fifoMem [FIFO_DEPTH];
    laneWordT headWord;
    logic [PtrW-1:0] wrPtrQ, rdPtrQ;
    logic [PtrW:0]   fifoCountQ;
    logic            fifoFull, fifoEmpty, push, pop;

    logic [CNT_W-1:0] intervalCntQ;
    logic             pendingQ, missedQ, inPktQ, inPktD, expire, skpNow;

    logic [31:0] txDataQ, txDataD;
    logic [3:0]  txDataKQ, txDataKD;
    logic        txValidQ, txValidD;

    assign fifoFull  = (fifoCountQ == FifoFullCount);
    assign fifoEmpty = (fifoCountQ == '0);
    assign in_ready  = ~fifoFull;
    assign push      = in_valid & ~fifoFull;
    assign headWord  = fifoMem[rdPtrQ];
    assign expire    = skp_en & (intervalCntQ == CntMax);

    // A SKP never goes out inside a packet; skp_en low suppresses a pending one.
    assign skpNow = pendingQ & skp_en & ~inPktQ;

    always_comb begin
        stateD   = StPass;
        pop      = 1'b0;
        inPktD   = inPktQ;
        txDataD  = '0;
        txDataKD = '0;
        txValidD = 1'b0;
        if (skpNow) begin
            stateD   = StSkp;
            txDataD  = SkpWord;
            txDataKD = 4'hF;
            txValidD = 1'b1;
        end else if (!fifoEmpty) begin
            pop      = 1'b1;
            txDataD  = headWord.data;
            txDataKD = headWord.datak;
            txValidD = 1'b1;
            if (headWord.eop) begin
                inPktD = 1'b0;
            end else if (headWord.sop) begin
                inPktD = 1'b1;
            end
        end else if (skp_en) begin
            txValidD = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (push) begin
            fifoMem[wrPtrQ] <= '{data: in_data, datak: in_datak, sop: in_sop, eop: in_eop};
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wrPtrQ     <= '0;
            rdPtrQ     <= '0;
            fifoCountQ <= '0;
        end else begin
            if (push) begin
                wrPtrQ <= wrPtrQ + 1'b1;
            end
            if (pop) begin
                rdPtrQ <= rdPtrQ + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifoCountQ <= fifoCountQ + 1'b1;
                2'b01:   fifoCountQ <= fifoCountQ - 1'b1;
                default: fifoCountQ <= fifoCountQ;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            intervalCntQ <= '0;
            pendingQ     <= 1'b0;
            missedQ      <= 1'b0;
        end else if (!skp_en) begin
            intervalCntQ <= '0;
            pendingQ     <= 1'b0;
        end else if (expire) begin
            intervalCntQ <= '0;
            pendingQ     <= 1'b1;
            // A SKP leaving on this very edge consumes the old request.
            if (pendingQ && !skpNow) begin
                missedQ <= 1'b1;
            end
        end else begin
            intervalCntQ <= intervalCntQ + 1'b1;
            if (skpNow) begin
                pendingQ <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            stateQ   <= StPass;
            inPktQ   <= 1'b0;
            txDataQ  <= '0;
            txDataKQ <= '0;
            txValidQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            inPktQ   <= inPktD;
            txDataQ  <= txDataD;
            txDataKQ <= txDataKD;
            txValidQ <= txValidD;
        end
    end

    assign TxData      = txDataQ;
    assign TxDataK     = txDataKQ;
    assign TxDataValid = txValidQ;
    assign skp_sent    = (stateQ == StSkp);
    assign missed_skp  = missedQ;

`ifdef SKP_INSERT_STATS_EN
    logic [15:0] skpCountQ;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            skpCountQ <= '0;
        end else if (skpNow) begin
            skpCountQ <= skpCountQ + 16'd1;
        end
    end

    assign skp_count = skpCountQ;
`endif

endmodule
